// File: rtl/ahfp_sub_seq.sv
// Multi-cycle single-precision subtractor: result = dataa - datab, round-to-nearest-even,
// denormals flushed, NaN/Inf inputs give canonical NaN.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// ALIGN  | order operands by magnitude, shift smaller one into G/R/S datapath
// ADDSUB | effective add or subtract of aligned significands
// NORM   | fix carry-out or leading zeros, adjust exponent
// ROUND  | round-to-nearest-even, pack/saturate/flush into result
// DONE   | result held with out_valid until consumed
module ahfp_sub_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]       opa, opb;
    logic              nan_q, sub_q, sign_q, zero_q;
    logic [7:0]        exp_q;
    logic [26:0]       mant_l_q, mant_s_q, mant_n_q;
    logic [27:0]       sum_q;
    logic signed [9:0] expn_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ALIGN;
            end
            ALIGN:  state_nxt = ADDSUB;
            ADDSUB: state_nxt = NORM;
            NORM:   state_nxt = ROUND;
            ROUND:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [7:0]  ea, eb, ediff;
    logic [23:0] ma, mb;
    logic        a_ge_b;
    logic [26:0] ext_s, aligned_s;
    logic [53:0] wide;

    assign ea     = opa[30:23];
    assign eb     = opb[30:23];
    assign ma     = (ea == 8'd0) ? 24'd0 : {1'b1, opa[22:0]};
    assign mb     = (eb == 8'd0) ? 24'd0 : {1'b1, opb[22:0]};
    assign a_ge_b = {ea, ma[22:0]} >= {eb, mb[22:0]};
    assign ediff  = a_ge_b ? (ea - eb) : (eb - ea);
    assign ext_s  = {a_ge_b ? mb : ma, 3'b000};

    // Bits pushed below R are collapsed into the sticky position.
    always_comb begin
        wide = {ext_s, 27'd0} >> ediff;
        if (ediff >= 8'd27) aligned_s = {26'd0, |ext_s};
        else                aligned_s = {wide[53:28], wide[27] | (|wide[26:0])};
    end

    logic [4:0] lz;
    logic       found;

    always_comb begin
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (sum_q[i]) found = 1'b1;
                else          lz    = lz + 5'd1;
            end
        end
    end

    logic              round_up;
    logic [24:0]       rnd;
    logic signed [9:0] expr;
    logic [22:0]       frac;
    logic [31:0]       packed_res;

    always_comb begin
        round_up = mant_n_q[2] & (mant_n_q[1] | mant_n_q[0] | mant_n_q[3]);
        rnd      = {1'b0, mant_n_q[26:3]} + {24'd0, round_up};
        expr     = rnd[24] ? (expn_q + 10'sd1) : expn_q;
        frac     = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (nan_q)                             packed_res = 32'h7FC0_0000;
        else if (zero_q || expr <= 10'sd0)     packed_res = 32'h0000_0000;
        else if (expr >= 10'sd255)             packed_res = {sign_q, 8'hFF, 23'd0};
        else                                   packed_res = {sign_q, expr[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa      <= '0;
            opb      <= '0;
            nan_q    <= 1'b0;
            sub_q    <= 1'b0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            exp_q    <= '0;
            mant_l_q <= '0;
            mant_s_q <= '0;
            mant_n_q <= '0;
            sum_q    <= '0;
            expn_q   <= '0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa <= dataa;
                        opb <= datab;
                    end
                end
                ALIGN: begin
                    nan_q    <= (ea == 8'hFF) || (eb == 8'hFF);
                    exp_q    <= a_ge_b ? ea : eb;
                    mant_l_q <= {a_ge_b ? ma : mb, 3'b000};
                    mant_s_q <= aligned_s;
                    sub_q    <= (opa[31] == opb[31]);
                    sign_q   <= a_ge_b ? opa[31] : ~opb[31];
                end
                ADDSUB: begin
                    if (sub_q) sum_q <= {1'b0, mant_l_q} - {1'b0, mant_s_q};
                    else       sum_q <= {1'b0, mant_l_q} + {1'b0, mant_s_q};
                end
                NORM: begin
                    zero_q <= (sum_q == 28'd0);
                    if (sum_q[27]) begin
                        mant_n_q <= {sum_q[27:2], sum_q[1] | sum_q[0]};
                        expn_q   <= $signed({2'b00, exp_q}) + 10'sd1;
                    end else begin
                        mant_n_q <= sum_q[26:0] << lz;
                        expn_q   <= $signed({2'b00, exp_q}) - $signed({5'd0, lz});
                    end
                end
                ROUND: result <= packed_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahfp_sub_seq.sv
// Randomised and directed bench for ahfp_sub_seq against a real-arithmetic reference.
module tb_ahfp_sub_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ahfp_sub_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Exact difference in double, then rounded once more to 24 bits with an unbounded exponent.
    function automatic logic [31:0] model_sub(input logic [31:0] a, input logic [31:0] b);
        real         rd;
        logic [63:0] db;
        logic [28:0] rem;
        logic [24:0] rk;
        int          e;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        rd = to_real(a) - to_real(b);
        if (rd == 0.0) return 32'h0;
        db  = $realtobits(rd);
        e   = int'(db[62:52]) - 896;
        rk  = {2'b01, db[51:29]};
        rem = db[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && rk[0])) rk = rk + 25'd1;
        if (rk[24]) begin
            e  = e + 1;
            rk = rk >> 1;
        end
        if (e <= 0) return 32'h0;
        if (e >= 255) return {db[63], 8'hFF, 23'd0};
        return {db[63], e[7:0], rk[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] want;
        want      = model_sub(a, b);
        dataa     = a;
        datab     = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
        tick();
        dataa = $urandom;
        datab = $urandom;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_val("busy_out_valid", {31'd0, out_valid}, 32'd0);
            check_val("busy_in_ready", {31'd0, in_ready}, 32'd0);
        end
        tick();
        check_val("done_out_valid", {31'd0, out_valid}, 32'd1);
        check_val("result", result, want);
        for (int h = 0; h < hold; h++) begin
            dataa = $urandom;
            datab = $urandom;
            tick();
            check_val("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_result", result, want);
            check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("post_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("post_result", result, want);
    endtask

    function automatic logic [31:0] pick_b(input logic [31:0] a, input int mode);
        logic [7:0] e;
        case (mode)
            0: return $urandom;
            1: begin
                e = a[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
                return {1'($urandom_range(0, 1)), e, 23'($urandom)};
            end
            2: return {1'($urandom_range(0, 1)), a[30:0]};
            3: return {a[31], a[30:23], a[22:0] ^ 23'($urandom_range(0, 7))};
            4: return {1'($urandom_range(0, 1)), a[30:23] - 8'($urandom_range(20, 30)), 23'($urandom)};
            default: return {1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                             23'($urandom)};
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dataa     = '0;
        datab     = '0;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", result, 32'h0);

        run_op(32'h4040_0000, 32'h3F80_0000, 0);
        check_val("dir_3_minus_1", result, 32'h4000_0000);
        run_op(32'h3F80_0000, 32'h3F80_0000, 0);
        check_val("dir_cancel", result, 32'h0000_0000);
        run_op(32'h4000_0000, 32'hC080_0000, 1);
        check_val("dir_2_minus_m4", result, 32'h40C0_0000);
        run_op(32'h3F80_0000, 32'h3300_0000, 0);
        check_val("dir_tie_even", result, 32'h3F80_0000);
        run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 0);
        check_val("dir_overflow", result, 32'h7F80_0000);
        run_op(32'h7F80_0000, 32'h3F80_0000, 3);
        check_val("dir_inf_nan", result, 32'h7FC0_0000);

        // Abort while the operation sits in ADDSUB.
        dataa     = 32'h4120_0000;
        datab     = 32'h3F80_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort_result", result, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end

        run_op(32'h4120_0000, 32'h3F80_0000, 0);

        // Reset wins over a handshake in the same cycle.
        dataa    = 32'h4040_0000;
        datab    = 32'h3F80_0000;
        in_valid = 1'b1;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_val("rst_hs_result", result, 32'h0);
        for (int i = 0; i < 6; i++) begin
            check_val("rst_hs_in_ready", {31'd0, in_ready}, 32'd1);
            check_val("rst_hs_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(30, 225));
            b = pick_b(a, int'($urandom_range(0, 5)));
            if ($urandom_range(0, 1) != 0) begin
                logic [31:0] t;
                t = a;
                a = b;
                b = t;
            end
            run_op(a, b, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
